gpio_irq_ctrl: RTL and testbench

//  Per-pin edge-detect interrupt controller placed directly downstream of the GPIO core.

---
 rtl/gpio_irq_pkg.sv | 25 ++
 rtl/gpio_irq_ctrl_debounce.sv | 58 +++++
 rtl/gpio_irq_ctrl.sv | 77 +++++++
 tb/tb_gpio_irq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO edge-interrupt controller: edge-select encoding,
// arm-counter sizing and a helper that maps detected edges through the select code.
package gpio_irq_pkg;

   localparam logic [1:0] EDGE_NONE = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_ANY  = 2'b11;

   localparam int                   ARM_CNT_W = 2;
   localparam logic [ARM_CNT_W-1:0] ARM_DONE  = 2'd3;

   // sel is {fall_enable, rise_enable}
   function automatic logic edge_hit(input logic [1:0] sel, input logic rise, input logic fall);
      logic hit;
      case (sel)
         EDGE_RISE: hit = rise;
         EDGE_FALL: hit = fall;
         EDGE_ANY:  hit = rise | fall;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/gpio_irq_ctrl_debounce.sv
// Per-pin resynchroniser with optional debounce filter producing the accepted level.
// Debounce is built only when GPIO_IRQ_DEBOUNCE_EN is defined; otherwise lvl = s2.
module gpio_irq_debounce
   import gpio_irq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic i_pin,
   output logic o_lvl
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("gpio_irq_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic r_s1;
   logic r_s2;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_pin;
         r_s2 <= r_s1;
      end
   end

`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;

   // Any return to the accepted level restarts the qualification window.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (r_s2 == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_DONE) begin
         r_stable <= r_s2;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_lvl = r_stable;
`else
   assign o_lvl = r_s2;
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Per-pin edge-detect interrupt controller with W1C pending register and OR-ed irq_out.
// Optional per-pin debounce is enabled by defining GPIO_IRQ_DEBOUNCE_EN.
module gpio_irq_ctrl
   import gpio_irq_pkg::*;
#(
   parameter int GPIO_PORT_NUM   = 32,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [GPIO_PORT_NUM-1:0] gpio_input_val,
   input  logic [GPIO_PORT_NUM-1:0] ctrl_irq_en,
   input  logic [GPIO_PORT_NUM-1:0] ctrl_irq_rise,
   input  logic [GPIO_PORT_NUM-1:0] ctrl_irq_fall,
   input  logic                     irq_clr_valid,
   input  logic [GPIO_PORT_NUM-1:0] irq_clr_mask,
   output logic [GPIO_PORT_NUM-1:0] irq_pending,
   output logic                     irq_out
);

   logic [GPIO_PORT_NUM-1:0] w_lvl;
   logic [GPIO_PORT_NUM-1:0] r_prev;
   logic [GPIO_PORT_NUM-1:0] w_set;
   logic [GPIO_PORT_NUM-1:0] w_clr;
   logic [GPIO_PORT_NUM-1:0] r_pending;
   logic [ARM_CNT_W-1:0]     r_arm_cnt;
   logic                     w_armed;
   logic                     r_irq_out;

   for (genvar g = 0; g < GPIO_PORT_NUM; g++) begin : g_pin
      gpio_irq_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .i_pin     (gpio_input_val[g]),
         .o_lvl     (w_lvl[g])
      );
   end

   // Edges are masked until the counter saturates so the reset value of prev
   // cannot fake an edge on pins already high.
   assign w_armed = (r_arm_cnt == ARM_DONE);

   always_comb begin
      w_set = '0;
      for (int i = 0; i < GPIO_PORT_NUM; i++) begin
         w_set[i] = w_armed & ctrl_irq_en[i] &
                    edge_hit({ctrl_irq_fall[i], ctrl_irq_rise[i]},
                             w_lvl[i] & ~r_prev[i],
                             ~w_lvl[i] & r_prev[i]);
      end
   end

   assign w_clr = irq_clr_valid ? irq_clr_mask : '0;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_prev    <= '0;
         r_arm_cnt <= '0;
         r_pending <= '0;
         r_irq_out <= 1'b0;
      end else begin
         r_prev    <= w_lvl;
         if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
         end
         // Set wins over a same-cycle clear.
         r_pending <= (r_pending & ~w_clr) | w_set;
         r_irq_out <= |r_pending;
      end
   end

   assign irq_pending = r_pending;
   assign irq_out     = r_irq_out;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed, table-driven bench for gpio_irq_ctrl; expectations are hand-computed
// and adapt to the GPIO_IRQ_DEBOUNCE_EN build with DEBOUNCE_CYCLES=4.
module tb_gpio_irq_ctrl;

   localparam int N  = 32;
   localparam int DB = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int          LAT         = 2 + DB + 1;
   localparam logic [N-1:0] GLITCH_EXP = 32'h0;
`else
   localparam int          LAT         = 2;
   localparam logic [N-1:0] GLITCH_EXP = 32'h200;
`endif

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic [N-1:0] gpio_input_val = '0;
   logic [N-1:0] ctrl_irq_en = '0;
   logic [N-1:0] ctrl_irq_rise = '0;
   logic [N-1:0] ctrl_irq_fall = '0;
   logic         irq_clr_valid = 1'b0;
   logic [N-1:0] irq_clr_mask = '0;
   logic [N-1:0] irq_pending;
   logic         irq_out;

   gpio_irq_ctrl #(
      .GPIO_PORT_NUM   (N),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .gpio_input_val (gpio_input_val),
      .ctrl_irq_en    (ctrl_irq_en),
      .ctrl_irq_rise  (ctrl_irq_rise),
      .ctrl_irq_fall  (ctrl_irq_fall),
      .irq_clr_valid  (irq_clr_valid),
      .irq_clr_mask   (irq_clr_mask),
      .irq_pending    (irq_pending),
      .irq_out        (irq_out)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [N-1:0] pins;
      logic [N-1:0] en;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic         clr_v;
      logic [N-1:0] clr_m;
      logic [N-1:0] exp_pend;
      logic         exp_irq;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic add(input logic [N-1:0] pins, input logic [N-1:0] en,
                      input logic [N-1:0] clr_m, input logic [N-1:0] ep, input logic ei);
      vec_t v;
      v.pins     = pins;
      v.en       = en;
      v.rise     = 32'h8C;
      v.fall     = 32'hA0;
      v.clr_v    = (clr_m != '0);
      v.clr_m    = clr_m;
      v.exp_pend = ep;
      v.exp_irq  = ei;
      vecs.push_back(v);
   endtask

   initial begin
      logic [N-1:0] ena;
      logic [N-1:0] enb;
      ena = 32'hAC;
      enb = 32'hA8;
      // pin3 rise, then W1C
      add(32'h00, ena, 0, 32'h00, 0);
      add(32'h08, ena, 0, 32'h00, 0);
      add(32'h08, ena, 0, 32'h00, 0);
      add(32'h08, ena, 0, 32'h08, 0);
      add(32'h08, ena, 0, 32'h08, 1);
      add(32'h08, ena, 32'h08, 32'h00, 1);
      add(32'h08, ena, 0, 32'h00, 0);
      // pin5 fall-only: rise ignored, fall sets
      add(32'h28, ena, 0, 32'h00, 0);
      add(32'h28, ena, 0, 32'h00, 0);
      add(32'h28, ena, 0, 32'h00, 0);
      add(32'h08, ena, 0, 32'h00, 0);
      add(32'h08, ena, 0, 32'h00, 0);
      add(32'h08, ena, 0, 32'h20, 0);
      add(32'h08, ena, 0, 32'h20, 1);
      add(32'h08, ena, 32'h20, 32'h00, 1);
      add(32'h08, ena, 0, 32'h00, 0);
      // pin2 set, then enable dropped: bit held, new edge blocked
      add(32'h0C, ena, 0, 32'h00, 0);
      add(32'h0C, ena, 0, 32'h00, 0);
      add(32'h0C, ena, 0, 32'h04, 0);
      add(32'h08, enb, 0, 32'h04, 1);
      add(32'h0C, enb, 0, 32'h04, 1);
      add(32'h0C, enb, 0, 32'h04, 1);
      add(32'h0C, enb, 0, 32'h04, 1);
      add(32'h0C, enb, 0, 32'h04, 1);
      add(32'h0C, enb, 32'h04, 32'h00, 1);
      add(32'h0C, enb, 0, 32'h00, 0);
      // pin7 any-edge: clear in the set cycle loses
      add(32'h8C, enb, 0, 32'h00, 0);
      add(32'h8C, enb, 0, 32'h00, 0);
      add(32'h8C, enb, 32'h80, 32'h80, 0);
      add(32'h8C, enb, 0, 32'h80, 1);
      add(32'h8C, enb, 32'h80, 32'h00, 1);
      add(32'h8C, enb, 0, 32'h00, 0);
      add(32'h0C, enb, 0, 32'h00, 0);
      add(32'h0C, enb, 0, 32'h00, 0);
      add(32'h0C, enb, 0, 32'h80, 0);
      add(32'h0C, enb, 0, 32'h80, 1);
      add(32'h0C, enb, 32'hFF, 32'h00, 1);
      add(32'h0C, enb, 0, 32'h00, 0);

      // reset with all pins high and every rise enabled
      gpio_input_val = '1;
      ctrl_irq_en    = '1;
      ctrl_irq_rise  = '1;
      repeat (3) tick();
      chk("reset_pend", irq_pending, '0);
      chk("reset_irq", {31'b0, irq_out}, '0);
      sys_rst_n = 1'b1;
`ifndef GPIO_IRQ_DEBOUNCE_EN
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("arm_pend_c%0d", c), irq_pending, '0);
         chk($sformatf("arm_irq_c%0d", c), {31'b0, irq_out}, '0);
      end

      gpio_input_val = '0;
      ctrl_irq_en    = '0;
      ctrl_irq_rise  = '0;
      repeat (5) tick();

      for (int i = 0; i < vecs.size(); i++) begin
         gpio_input_val = vecs[i].pins;
         ctrl_irq_en    = vecs[i].en;
         ctrl_irq_rise  = vecs[i].rise;
         ctrl_irq_fall  = vecs[i].fall;
         irq_clr_valid  = vecs[i].clr_v;
         irq_clr_mask   = vecs[i].clr_m;
         tick();
         chk($sformatf("vec%0d_pend", i), irq_pending, vecs[i].exp_pend);
         chk($sformatf("vec%0d_irq", i), {31'b0, irq_out}, {31'b0, vecs[i].exp_irq});
      end
      irq_clr_valid = 1'b0;
      irq_clr_mask  = '0;
`endif

      // fresh reset with quiet pins before the filter tests
      sys_rst_n      = 1'b0;
      gpio_input_val = '0;
      ctrl_irq_en    = '0;
      ctrl_irq_rise  = '0;
      ctrl_irq_fall  = '0;
      repeat (2) tick();
      chk("reset2_pend", irq_pending, '0);
      sys_rst_n = 1'b1;
      repeat (8 + DB) tick();
      ctrl_irq_en   = 32'h200;
      ctrl_irq_rise = 32'h200;

      // 3-cycle glitch on pin9
      gpio_input_val = 32'h200;
      repeat (3) tick();
      gpio_input_val = '0;
      repeat (15) tick();
      chk("glitch_pend", irq_pending, GLITCH_EXP);
      irq_clr_valid = 1'b1;
      irq_clr_mask  = 32'h200;
      tick();
      irq_clr_valid = 1'b0;
      irq_clr_mask  = '0;
      chk("glitch_clr", irq_pending, '0);
      repeat (3) tick();
      chk("glitch_irq_idle", {31'b0, irq_out}, '0);

      // 6-cycle high on pin9: pending appears exactly LAT edges after first sample
      for (int c = 0; c <= LAT + 2; c++) begin
         gpio_input_val = (c < 6) ? 32'h200 : 32'h0;
         tick();
         chk($sformatf("hold6_c%0d", c), irq_pending, (c >= LAT) ? 32'h200 : 32'h0);
      end
      gpio_input_val = '0;
      tick();
      chk("hold6_irq", {31'b0, irq_out}, 32'h1);

      // asynchronous reset mid-operation
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_pend", irq_pending, '0);
      chk("midrst_irq", {31'b0, irq_out}, '0);
      repeat (2) tick();
      sys_rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_pend", irq_pending, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
